regfile_access_ctrl: RTL and testbench

- Sequences all accesses to the two-entry button-control register file: entry 0 is live system data, read-only; entry 1 is the flags/command register, read/write.
- Two requesters share the file's single write/read port: host bus (h_*) and internal robot/game system logic (s_*).
- Arbitrates round-robin, drives the register-file control signals, waits for its done pulse, and returns ack/data/error to the granted requester.

---
 rtl/regfile_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Round-robin access sequencer for the two-entry button-control register file.
// Host and system requesters share one rf port; entry 0 is read-only live data.
module regfile_access_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  h_req,
   input  logic                  h_wr,
   input  logic                  h_addr,
   input  logic [DATA_WIDTH-1:0] h_wdata,
   output logic                  h_ack,
   output logic [DATA_WIDTH-1:0] h_rdata,
   output logic                  h_err,
   input  logic                  s_req,
   input  logic                  s_wr,
   input  logic                  s_addr,
   input  logic [DATA_WIDTH-1:0] s_wdata,
   output logic                  s_ack,
   output logic [DATA_WIDTH-1:0] s_rdata,
   output logic                  s_err,
   output logic                  rf_we,
   output logic                  rf_addr_wr,
   output logic                  rf_addr_rd,
   output logic [DATA_WIDTH-1:0] rf_wr_data,
   input  logic [DATA_WIDTH-1:0] rf_rd_data,
   input  logic                  rf_done,
   output logic                  busy
);

   // state     | meaning
   // IDLE      | sample requests, grant, latch the access
   // ISSUE     | drive rf port for one cycle (write strobe or read address)
   // WAIT_DONE | wait for rf_done or time out
   // RESP      | one-cycle ack/err/rdata to the granted requester
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
   localparam logic [1:0] RESP      = 2'd3;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES);

   logic [1:0]            state;
   logic                  gnt;         // 0 = host, 1 = system
   logic                  last_grant;
   logic                  wr_q;
   logic                  addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_inc;
   logic                  req_any;
   logic                  sel_sys;
   logic                  sel_wr;
   logic                  sel_addr;
   logic                  timed_out;
   logic                  ld_rdata;
   logic                  ld_sys;
   logic [DATA_WIDTH-1:0] ld_value;

   assign req_any   = h_req | s_req;
   assign sel_sys   = (h_req && s_req) ? ~last_grant : s_req;
   assign sel_wr    = sel_sys ? s_wr : h_wr;
   assign sel_addr  = sel_sys ? s_addr : h_addr;
   assign cnt_inc   = cnt + 1'b1;
   assign timed_out = (cnt_inc == TIMEOUT_TC);

   // Response data is loaded on the edge that enters RESP; writes and
   // rejected accesses return zero.
   always_comb begin
      ld_rdata = 1'b0;
      ld_sys   = gnt;
      ld_value = '0;
      case (state)
         IDLE: begin
            ld_sys   = sel_sys;
            ld_rdata = req_any && sel_wr && !sel_addr;
         end
         ISSUE: begin
            ld_rdata = !wr_q;
            ld_value = rf_rd_data;
         end
         WAIT_DONE: ld_rdata = rf_done || timed_out;
         default: ld_rdata = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         wr_q       <= 1'b0;
         addr_q     <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         cnt        <= '0;
         rf_addr_wr <= 1'b0;
         rf_wr_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  gnt     <= sel_sys;
                  wr_q    <= sel_wr;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_sys ? s_wdata : h_wdata;
                  if (sel_wr && !sel_addr) begin
                     err_q <= 1'b1;
                     state <= RESP;
                  end else begin
                     if (sel_wr) begin
                        rf_addr_wr <= sel_addr;
                        rf_wr_data <= sel_sys ? s_wdata : h_wdata;
                     end
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               err_q <= 1'b0;
               if (wr_q) begin
                  cnt   <= '0;
                  state <= WAIT_DONE;
               end else begin
                  state <= RESP;
               end
            end
            WAIT_DONE: begin
               if (rf_done) begin
                  err_q <= 1'b0;
                  state <= RESP;
               end else if (timed_out) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               last_grant <= gnt;
               state      <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_rdata <= '0;
         s_rdata <= '0;
      end else if (ld_rdata) begin
         if (ld_sys) s_rdata <= ld_value;
         else        h_rdata <= ld_value;
      end
   end

   assign busy       = (state != IDLE);
   assign rf_we      = (state == ISSUE) && wr_q;
   assign rf_addr_rd = (state == ISSUE) && !wr_q && addr_q;
   assign h_ack      = (state == RESP) && !gnt;
   assign s_ack      = (state == RESP) && gnt;
   assign h_err      = h_ack && err_q;
   assign s_err      = s_ack && err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: a vector table of single accesses
// plus hand sequences for arbitration, timeout and mid-access reset.
module tb_regfile_access_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          h_req, h_wr, h_addr;
   logic [DW-1:0] h_wdata, h_rdata;
   logic          h_ack, h_err;
   logic          s_req, s_wr, s_addr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          s_ack, s_err;
   logic          rf_we, rf_addr_wr, rf_addr_rd, rf_done, busy;
   logic [DW-1:0] rf_wr_data, rf_rd_data;

   logic          done_en;
   logic [DW-1:0] ent0;
   logic [DW-1:0] ent1;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_access_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rdata(h_rdata), .h_err(h_err),
      .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata), .s_err(s_err),
      .rf_we(rf_we), .rf_addr_wr(rf_addr_wr), .rf_addr_rd(rf_addr_rd),
      .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_done(rf_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Register-file model: done one cycle after the write strobe, combinational read.
   always @(posedge clk) begin
      rf_done <= done_en & rf_we;
      if (rf_we && rf_addr_wr) ent1 <= rf_wr_data;
   end
   assign rf_rd_data = rf_addr_rd ? ent1 : ent0;

   typedef struct {
      logic          sys;
      logic          wr;
      logic          addr;
      logic [DW-1:0] wdata;
      int            lat;
      logic          err;
      logic [DW-1:0] rdata;
      int            we_cnt;
      logic          addr_rd;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_access(input logic sys, input logic wr, input logic addr,
                            input logic [DW-1:0] wdata,
                            output int lat, output logic err, output logic [DW-1:0] rdata,
                            output int we_cnt, output logic other_ack,
                            output logic [DW-1:0] we_data, output logic we_addr,
                            output logic addr_rd);
      lat = 0; err = 1'bx; rdata = 'x; we_cnt = 0; other_ack = 1'b0;
      we_data = '0; we_addr = 1'b0; addr_rd = 1'bx;
      @(negedge clk);
      if (sys) begin s_req = 1'b1; s_wr = wr; s_addr = addr; s_wdata = wdata; end
      else     begin h_req = 1'b1; h_wr = wr; h_addr = addr; h_wdata = wdata; end
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (rf_we) begin we_cnt++; we_data = rf_wr_data; we_addr = rf_addr_wr; end
         if (c == 1) addr_rd = rf_addr_rd;
         if (sys ? h_ack : s_ack) other_ack = 1'b1;
         if (sys ? s_ack : h_ack) begin
            lat   = c;
            err   = sys ? s_err : h_err;
            rdata = sys ? s_rdata : h_rdata;
            h_req = 1'b0; s_req = 1'b0;
            break;
         end
      end
      h_req = 1'b0; s_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_pair(input logic host_first, input string tag);
      int hc = 0;
      int sc = 0;
      logic [DW-1:0] first_we = '0;
      logic seen_we = 1'b0;
      @(negedge clk);
      h_req = 1'b1; h_wr = 1'b1; h_addr = 1'b1; h_wdata = 32'h1111_1111;
      s_req = 1'b1; s_wr = 1'b1; s_addr = 1'b1; s_wdata = 32'h2222_2222;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (rf_we && !seen_we) begin seen_we = 1'b1; first_we = rf_wr_data; end
         if (h_ack && hc == 0) begin hc = c; h_req = 1'b0; end
         if (s_ack && sc == 0) begin sc = c; s_req = 1'b0; end
         if (hc != 0 && sc != 0) break;
      end
      h_req = 1'b0; s_req = 1'b0;
      chk({tag, "_h_lat"}, hc, host_first ? 3 : 7);
      chk({tag, "_s_lat"}, sc, host_first ? 7 : 3);
      chk({tag, "_first_we"}, first_we, host_first ? 32'h1111_1111 : 32'h2222_2222);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int            lat, we_cnt, acks;
      logic          err, other_ack, we_addr, addr_rd;
      logic [DW-1:0] rdata, we_data;

      vecs[0] = '{1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 3, 1'b0, 32'h0,         1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         2, 1'b0, 32'h0000_00F3, 0, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         2, 1'b0, 32'hA5A5_0001, 0, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1'b1, 32'h0,         0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h0,         1, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         2, 1'b0, 32'h1234_5678, 0, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 32'hCAFE_0000, 1, 1'b1, 32'h0,         0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0,         2, 1'b0, 32'h1234_5678, 0, 1'b1};

      rst_n = 1'b0; done_en = 1'b1; ent0 = 32'h0000_00F3; ent1 = '0;
      h_req = 0; h_wr = 0; h_addr = 0; h_wdata = '0;
      s_req = 0; s_wr = 0; s_addr = 0; s_wdata = '0;
      #1;
      chk("reset_ctrl", {24'b0, h_ack, h_err, s_ack, s_err, rf_we, rf_addr_wr, rf_addr_rd, busy}, '0);
      chk("reset_data", h_rdata | s_rdata | rf_wr_data, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_access(vecs[i].sys, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   lat, err, rdata, we_cnt, other_ack, we_data, we_addr, addr_rd);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
         chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
         chk($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].we_cnt);
         chk($sformatf("v%0d_other_ack", i), {31'b0, other_ack}, '0);
         if (!vecs[i].wr)
            chk($sformatf("v%0d_addr_rd", i), {31'b0, addr_rd}, {31'b0, vecs[i].addr});
         if (vecs[i].wr && vecs[i].addr) begin
            chk($sformatf("v%0d_we_data", i), we_data, vecs[i].wdata);
            chk($sformatf("v%0d_we_addr", i), {31'b0, we_addr}, 32'd1);
         end
      end

      // Last grant was system, so host wins twice in a row.
      do_pair(1'b1, "pair1");
      do_pair(1'b1, "pair2");

      done_en = 1'b0;
      do_access(1'b0, 1'b1, 1'b1, 32'h0BAD_0001,
                lat, err, rdata, we_cnt, other_ack, we_data, we_addr, addr_rd);
      chk("tmo_lat", lat, 10);
      chk("tmo_err", {31'b0, err}, 32'd1);
      chk("tmo_we_cnt", we_cnt, 1);
      chk("tmo_busy", {31'b0, busy}, '0);
      done_en = 1'b1;

      // Last grant now host, so system wins the tie.
      do_pair(1'b0, "pair3");

      done_en = 1'b0;
      @(negedge clk);
      h_req = 1'b1; h_wr = 1'b1; h_addr = 1'b1; h_wdata = 32'h7777_0007;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctrl", {24'b0, h_ack, h_err, s_ack, s_err, rf_we, rf_addr_wr, rf_addr_rd, busy}, '0);
      chk("mid_rst_data", h_rdata | s_rdata | rf_wr_data, '0);
      h_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (h_ack || s_ack) acks++;
      end
      chk("mid_rst_no_ack", acks, 0);
      done_en = 1'b1;
      @(negedge clk);
      do_pair(1'b1, "pair_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
